// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: stalls, flushes, forwarding, MDU wait.
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic             we_reg_E,
  input  logic             is_load_E,
  input  logic             mdu_op_E,
  input  logic             branch_taken_E,
  input  logic [4:0]       rd_M,
  input  logic [4:0]       rd_W,
  input  logic             we_reg_M,
  input  logic             we_reg_W,
  input  logic             dmem_req_M,
  input  logic             dmem_ready_M,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_M,
  output logic             flush_W,
  output logic [1:0]       fwd_a_E,
  output logic [1:0]       fwd_b_E,
  output logic             mdu_done,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  typedef enum logic [0:0] {StRun, StMduWait} state_e;

  state_e     state_q, state_d;
  logic [3:0] mdu_cnt_q, mdu_cnt_d;
  logic       mem_wait, load_use;
  logic       s_f, s_d, s_e, s_m, f_d, f_e, f_m, f_w, done;
  logic [1:0] fa, fb;

  assign mem_wait = dmem_req_M & ~dmem_ready_M;
  assign load_use = is_load_E & we_reg_E & (rd_E != 5'd0) &
                    ((rd_E == rs1_D) | (rd_E == rs2_D));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      mdu_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mdu_cnt_d = mdu_cnt_q;
    s_f  = 1'b0;
    s_d  = 1'b0;
    s_e  = 1'b0;
    s_m  = 1'b0;
    f_d  = 1'b0;
    f_e  = 1'b0;
    f_m  = 1'b0;
    f_w  = 1'b0;
    done = 1'b0;
    if (mem_wait) begin
      // Memory wait freezes the whole pipe; the FSM and counter hold.
      s_f = 1'b1;
      s_d = 1'b1;
      s_e = 1'b1;
      s_m = 1'b1;
      f_w = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (branch_taken_E) begin
            f_d = 1'b1;
            f_e = 1'b1;
          end else if (mdu_op_E) begin
            s_f       = 1'b1;
            s_d       = 1'b1;
            s_e       = 1'b1;
            f_m       = 1'b1;
            state_d   = StMduWait;
            mdu_cnt_d = 4'(MDU_LAT - 2);
          end else if (load_use) begin
            s_f = 1'b1;
            s_d = 1'b1;
            f_e = 1'b1;
          end
        end
        StMduWait: begin
          if (mdu_cnt_q != 4'd0) begin
            s_f       = 1'b1;
            s_d       = 1'b1;
            s_e       = 1'b1;
            f_m       = 1'b1;
            mdu_cnt_d = mdu_cnt_q - 4'd1;
          end else begin
            done    = 1'b1;
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    fa = 2'b00;
    if (we_reg_M && rd_M != 5'd0 && rd_M == rs1_E)      fa = 2'b10;
    else if (we_reg_W && rd_W != 5'd0 && rd_W == rs1_E) fa = 2'b01;
    fb = 2'b00;
    if (we_reg_M && rd_M != 5'd0 && rd_M == rs2_E)      fb = 2'b10;
    else if (we_reg_W && rd_W != 5'd0 && rd_W == rs2_E) fb = 2'b01;
  end

  // Every output is forced low while reset is held.
  assign stall_F  = rst_n & s_f;
  assign stall_D  = rst_n & s_d;
  assign stall_E  = rst_n & s_e;
  assign stall_M  = rst_n & s_m;
  assign flush_D  = rst_n & f_d;
  assign flush_E  = rst_n & f_e;
  assign flush_M  = rst_n & f_m;
  assign flush_W  = rst_n & f_w;
  assign mdu_done = rst_n & done;
  assign fwd_a_E  = rst_n ? fa : 2'b00;
  assign fwd_b_E  = rst_n ? fb : 2'b00;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_stall_q, cnt_flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_stall_q <= '0;
      cnt_flush_q <= '0;
    end else begin
      if (stall_F && cnt_stall_q != '1) cnt_stall_q <= cnt_stall_q + CNT_W'(1);
      if ((flush_D || flush_E) && cnt_flush_q != '1) cnt_flush_q <= cnt_flush_q + CNT_W'(1);
    end
  end

  assign cnt_stall = rst_n ? cnt_stall_q : '0;
  assign cnt_flush = rst_n ? cnt_flush_q : '0;
`else
  assign cnt_stall = '0;
  assign cnt_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expectations, a monitor checks them.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic we_reg_E, is_load_E, mdu_op_E, branch_taken_E, we_reg_M, we_reg_W;
  logic dmem_req_M, dmem_ready_M;
  logic stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M, flush_W, mdu_done;
  logic [1:0] fwd_a_E, fwd_b_E;
  logic [CNT_W-1:0] cnt_stall, cnt_flush;

  pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .we_reg_E(we_reg_E), .is_load_E(is_load_E), .mdu_op_E(mdu_op_E),
    .branch_taken_E(branch_taken_E), .rd_M(rd_M), .rd_W(rd_W),
    .we_reg_M(we_reg_M), .we_reg_W(we_reg_W),
    .dmem_req_M(dmem_req_M), .dmem_ready_M(dmem_ready_M),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M), .flush_W(flush_W),
    .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E), .mdu_done(mdu_done),
    .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            nm;
    logic [12:0]      exp;
    logic [CNT_W-1:0] cs;
    logic [CNT_W-1:0] cf;
  } item_t;

  item_t q[$];
  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] m_cs = '0;
  logic [CNT_W-1:0] m_cf = '0;

  always @(posedge clk)
    if (rst_n) assert (!(branch_taken_E && mdu_op_E)) else $error("illegal branch+mdu");

  // Packing: {sF,sD,sE,sM,fD,fE,fM,fW,fwd_a,fwd_b,done}
  function automatic logic [12:0] mk(input logic sf, sd, se, sm, fd, fe, fm, fw,
                                     input logic [1:0] fa, fb, input logic dn);
    return {sf, sd, se, sm, fd, fe, fm, fw, fa, fb, dn};
  endfunction

  always @(negedge clk) begin
    item_t it;
    logic [12:0] act;
    if (q.size() > 0) begin
      it  = q.pop_front();
      act = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M, flush_W,
             fwd_a_E, fwd_b_E, mdu_done};
      checks++;
      if (act !== it.exp || cnt_stall !== it.cs || cnt_flush !== it.cf) begin
        errors++;
        $display("FAIL %s: got %b cs=%0d cf=%0d, want %b cs=%0d cf=%0d",
                 it.nm, act, cnt_stall, cnt_flush, it.exp, it.cs, it.cf);
      end
    end
  end

  task automatic clr();
    rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
    we_reg_E = 0; is_load_E = 0; mdu_op_E = 0; branch_taken_E = 0;
    we_reg_M = 0; we_reg_W = 0; dmem_req_M = 0; dmem_ready_M = 0;
  endtask

  // Push the expectation for the current cycle, then advance to just after the next edge.
  task automatic cyc(input string nm, input logic [12:0] e);
    item_t it;
    if (!rst_n) begin
      m_cs = '0;
      m_cf = '0;
    end
    it.nm = nm; it.exp = e; it.cs = m_cs; it.cf = m_cf;
    q.push_back(it);
`ifdef HAZ_PERF_CNT_EN
    if (rst_n && e[12]) m_cs = m_cs + 1;
    if (rst_n && (e[8] || e[7])) m_cf = m_cf + 1;
`endif
    @(posedge clk);
    #1;
  endtask

  localparam logic [12:0] NONE  = 13'd0;
  logic [12:0] lu, mdu, mw, dn, br;

  initial begin
    lu  = mk(1, 1, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0);
    mdu = mk(1, 1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0);
    mw  = mk(1, 1, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0);
    dn  = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
    br  = mk(0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0);

    rst_n = 1'b0;
    clr();
    mdu_op_E = 1; dmem_req_M = 1; we_reg_M = 1; rd_M = 3; rs1_E = 3;
    @(posedge clk); #1;
    cyc("reset_outputs_zero", NONE);
    rst_n = 1'b1; clr();
    cyc("idle", NONE);

    is_load_E = 1; we_reg_E = 1; rd_E = 5; rs2_D = 5;
    cyc("load_use_rs2", lu);
    clr();
    cyc("load_use_one_cycle", NONE);
    is_load_E = 1; we_reg_E = 1; rd_E = 0; rs1_D = 0; rs2_D = 0;
    cyc("load_use_x0", NONE);
    clr(); is_load_E = 1; we_reg_E = 1; rd_E = 9; rs1_D = 9;
    cyc("load_use_rs1", lu);
    we_reg_E = 0;
    cyc("load_no_we", NONE);

    we_reg_E = 1; branch_taken_E = 1;
    cyc("branch_over_load_use", br);
    clr();

    mdu_op_E = 1;
    cyc("mdu_c0", mdu);
    cyc("mdu_c1", mdu);
    cyc("mdu_c2", mdu);
    cyc("mdu_c3_done", dn);
    clr();
    cyc("mdu_back_to_run", NONE);

    mdu_op_E = 1;
    cyc("mdu_mw_c0", mdu);
    dmem_req_M = 1; dmem_ready_M = 0;
    cyc("mdu_mw_c1", mw);
    cyc("mdu_mw_c2", mw);
    dmem_ready_M = 1;
    cyc("mdu_mw_c3", mdu);
    cyc("mdu_mw_c4", mdu);
    cyc("mdu_mw_c5_done", dn);
    clr();

    dmem_req_M = 1; is_load_E = 1; we_reg_E = 1; rd_E = 4; rs1_D = 4;
    cyc("mem_wait_over_load_use", mw);
    clr();

    rd_M = 7; rd_W = 7; we_reg_M = 1; we_reg_W = 1; rs1_E = 7; rs2_E = 7;
    cyc("fwd_mem", mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 0));
    we_reg_M = 0;
    cyc("fwd_wb", mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0));
    rs1_E = 0;
    cyc("fwd_none", mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0));
    rd_W = 0; rs2_E = 0;
    cyc("fwd_x0", NONE);
    we_reg_M = 1; rd_M = 3; rs2_E = 3; rd_W = 3;
    cyc("fwd_b_mem_pri", mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0));
    clr();

    mdu_op_E = 1;
    cyc("rst_mdu_c0", mdu);
    rst_n = 1'b0;
    cyc("rst_mid_mdu", NONE);
    rst_n = 1'b1; clr();
    cyc("rst_release_run", NONE);
    cyc("rst_release_run2", NONE);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d pending, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
